dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 126 ++++++++++++
 tb/tb_dcache_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache between MEM stage and SRAM controller
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int ADDR_W  = 19,
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = ADDR_W - 2 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state_q, state_d;
  logic sram_rd_en_q, sram_rd_en_d, sram_wr_en_q, sram_wr_en_d;
  logic [31:0] sram_address_q, sram_address_d, sram_write_data_q, sram_write_data_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0] data_mem [LINES];
  logic [INDEX_W-1:0] idx, l_idx;
  logic [TAG_W-1:0] tag, l_tag;
  logic hit, l_hit, idle, rd_hit, rd_miss, done, fill, upd;
  logic unused_ok;
  assign unused_ok = ^mem_address[1:0];
  assign idx = mem_address[INDEX_W+1:2];
  assign tag = mem_address[ADDR_W-1:INDEX_W+2];
  // Fill and write-through update use the latched address, not the live request.
  assign l_idx = sram_address_q[INDEX_W+1:2];
  assign l_tag = sram_address_q[ADDR_W-1:INDEX_W+2];
  assign hit = valid_q[idx] && tag_mem[idx] == tag;
  assign l_hit = valid_q[l_idx] && tag_mem[l_idx] == l_tag;
  assign idle = state_q == IDLE;
  assign rd_hit = idle && !mem_wr_en && mem_rd_en && hit;
  assign rd_miss = idle && !mem_wr_en && mem_rd_en && !hit;
  assign done = !idle && sram_ready;
  assign fill = state_q == RD_MISS && sram_ready;
  assign upd = state_q == WR_THRU && sram_ready && l_hit;
  assign mem_ready = idle ? !mem_wr_en && !rd_miss : sram_ready;
  assign mem_read_data = rd_hit ? data_mem[idx] : fill ? sram_read_data : 32'd0;
  assign sram_rd_en = sram_rd_en_q;
  assign sram_wr_en = sram_wr_en_q;
  assign sram_address = sram_address_q;
  assign sram_write_data = sram_write_data_q;
  always_comb begin
    state_d = state_q;
    sram_rd_en_d = sram_rd_en_q;
    sram_wr_en_d = sram_wr_en_q;
    sram_address_d = sram_address_q;
    sram_write_data_d = sram_write_data_q;
    valid_d = valid_q;
    if (fill) valid_d[l_idx] = 1'b1;
    if (idle && mem_wr_en) begin
      state_d = WR_THRU;
      sram_wr_en_d = 1'b1;
      sram_address_d = {mem_address[31:2], 2'b00};
      sram_write_data_d = mem_write_data;
    end else if (rd_miss) begin
      state_d = RD_MISS;
      sram_rd_en_d = 1'b1;
      sram_address_d = {mem_address[31:2], 2'b00};
    end else if (done) begin
      state_d = IDLE;
      sram_rd_en_d = 1'b0;
      sram_wr_en_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
      sram_address_q <= 32'd0;
      sram_write_data_q <= 32'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      sram_rd_en_q <= sram_rd_en_d;
      sram_wr_en_q <= sram_wr_en_d;
      sram_address_q <= sram_address_d;
      sram_write_data_q <= sram_write_data_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_mem[l_idx] <= l_tag;
      data_mem[l_idx] <= sram_read_data;
    end else if (upd && !rst) begin
      data_mem[l_idx] <= sram_write_data_q;
    end
  end
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
  always_comb begin
    hit_count_d = (rd_hit && ~&hit_count_q) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (rd_miss && ~&miss_count_q) ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: random + directed scoreboard bench for dcache_ctrl with an SRAM responder model
module tb_dcache_ctrl;
  logic clk = 0, rst = 1, mem_rd_en = 0, mem_wr_en = 0, sram_ready = 0;
  logic [31:0] mem_address = 0, mem_write_data = 0, sram_read_data = 0;
  logic [31:0] mem_read_data, sram_address, sram_write_data;
  logic mem_ready, sram_rd_en, sram_wr_en;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  dcache_ctrl dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data), .sram_ready(sram_ready)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit zl;
    int start;
    int nsram;
  } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0, force_lat = -1, n_sram = 0, last_lat = 0, n_hit = 0, n_miss = 0;
  bit mon_en = 0, busy = 0;
  int lat = 0;
  logic [31:0] mem_model [int];
  logic [31:0] sram_mem [int];
  bit cv [64];
  logic [10:0] ct [64];
  always @(posedge clk) cyc++;
  function automatic logic [31:0] init_val(int w);
    return (32'(w) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", n, act, exp, cyc);
    end
  endtask
  // SRAM controller model: waits lat cycles after seeing an enable, then pulses ready once
  initial forever begin
    int key;
    @(posedge clk); #2;
    sram_ready = 0;
    sram_read_data = 0;
    if (rst) busy = 0;
    else begin
      if (!busy && (sram_rd_en || sram_wr_en)) begin
        busy = 1;
        n_sram++;
        lat = force_lat >= 0 ? force_lat : int'($urandom_range(0, 4));
      end
      if (busy) begin
        if (lat == 0) begin
          busy = 0;
          sram_ready = 1;
          key = int'(sram_address[18:2]);
          if (sram_wr_en) sram_mem[key] = sram_write_data;
          else sram_read_data = sram_mem.exists(key) ? sram_mem[key] : init_val(key);
        end else lat--;
      end
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en && !rst) begin
      if (!mem_ready) chk("rdata_zero_when_stalled", mem_read_data, 0);
      if (!mem_rd_en && !mem_wr_en) chk("idle_ready", mem_ready, 1);
      if ((mem_rd_en || mem_wr_en) && mem_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("rdata", mem_read_data, e.wr ? 32'd0 : e.data);
          chk("zero_latency", (cyc - e.start) == 0, e.zl);
          if (e.zl) begin
            chk("hit_no_sram", n_sram, e.nsram);
            chk("hit_en_low", {sram_rd_en, sram_wr_en}, 0);
          end else begin
            chk("sram_ready_at_done", sram_ready, 1);
            chk("sram_en_at_done", e.wr ? sram_wr_en : sram_rd_en, 1);
            chk("sram_addr", sram_address, e.addr);
            if (e.wr) chk("sram_wdata", sram_write_data, e.data);
          end
        end
      end
    end
  end
  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int l);
    exp_t e;
    int k, w;
    logic [5:0] ix;
    logic [10:0] tg;
    bit hit;
    @(posedge clk); #1;
    force_lat = l;
    w = int'(a[18:2]);
    ix = a[7:2];
    tg = a[18:8];
    hit = cv[ix] && ct[ix] == tg;
    e.wr = wr;
    e.addr = {a[31:2], 2'b00};
    e.data = wr ? d : (mem_model.exists(w) ? mem_model[w] : init_val(w));
    e.zl = !wr && hit;
    e.start = cyc;
    e.nsram = n_sram;
    if (wr) mem_model[w] = d;
    else if (hit) n_hit++;
    else begin
      n_miss++;
      cv[ix] = 1;
      ct[ix] = tg;
    end
    q.push_back(e);
    mem_rd_en = !wr;
    mem_wr_en = wr;
    mem_address = a;
    mem_write_data = wr ? d : $urandom();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_ready && k < 40);
    if (!mem_ready) begin
      $display("FAIL timeout addr=%h got=no_ready exp=ready", a);
      $fatal(1, "request timeout");
    end
    last_lat = cyc - e.start;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_rd_en = 0;
      mem_wr_en = 0;
    end
  endtask
  initial begin
    foreach (cv[i]) cv[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_sram_rd_en", sram_rd_en, 0);
    chk("rst_sram_wr_en", sram_wr_en, 0);
    chk("rst_sram_address", sram_address, 0);
    chk("rst_sram_wdata", sram_write_data, 0);
    chk("rst_mem_ready", mem_ready, 1);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
`endif
    mon_en = 1;
    mem_model[32'h400 >> 2] = 32'hDEADBEEF;
    sram_mem[32'h400 >> 2] = 32'hDEADBEEF;
    req(0, 32'h400, 0, 5);
    chk("miss_latency", last_lat, 6);
    idle(1);
    @(negedge clk);
    chk("rd_en_drops", sram_rd_en, 0);
    req(0, 32'h400, 0, -1);
    chk("hit_latency", last_lat, 0);
    req(1, 32'h400, 32'h12345678, 3);
    req(0, 32'h400, 0, -1);
    chk("hit_after_write", last_lat, 0);
    req(1, 32'h800, 32'hCAFEF00D, -1);
    req(0, 32'h800, 0, -1);
    chk("no_alloc_miss", last_lat > 0, 1);
    req(0, 32'h500, 0, -1);
    req(0, 32'h400, 0, -1);
    chk("conflict_miss", last_lat > 0, 1);
    // abandon a read miss with reset while the SRAM is still busy
    @(posedge clk); #1;
    mon_en = 0;
    force_lat = 8;
    mem_rd_en = 1;
    mem_address = 32'h900;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    mem_rd_en = 0;
    @(posedge clk); #1 rst = 0;
    foreach (cv[i]) cv[i] = 0;
    n_hit = 0;
    n_miss = 0;
    @(negedge clk);
    chk("rst_mid_rd_en", sram_rd_en, 0);
    chk("rst_mid_ready", mem_ready, 1);
`ifdef DCACHE_STATS_EN
    chk("rst_mid_hit_count", hit_count, 0);
    chk("rst_mid_miss_count", miss_count, 0);
`endif
    mon_en = 1;
    req(0, 32'h400, 0, -1);
    chk("miss_after_reset", last_lat > 0, 1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) req(1, a & ~32'd3, $urandom(), -1);
      else req(0, a, 0, -1);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("queue_empty", q.size(), 0);
`ifdef DCACHE_STATS_EN
    chk("final_hit_count", hit_count, n_hit);
    chk("final_miss_count", miss_count, n_miss);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
